// File: rtl/test_game_sequencer.sv
// Scripted game-state source: walks a cursor over a baseline board, fills empty cells, flags errors and keeps score.
// Optional macro TEST_SEQ_TIMER_EN builds the 1 s tick divider and time_in_seconds; otherwise time_in_seconds is tied to 0.
//
// state | meaning
// IDLE  | reset values held, advances ignored
// PLAY  | advances fill cells and move the cursor
// DONE  | outputs frozen until start or reset
`timescale 1ns/1ps
module test_game_sequencer #(
    parameter int unsigned    CLK_HZ      = 50_000_000,
    parameter int unsigned    STEP_CYCLES = 25_000_000,
    parameter int unsigned    ERR_EVERY   = 4,
    parameter int unsigned    MAX_ENTRIES = 20,
    parameter logic           DIFFICULTY  = 1'b1,
    parameter logic [323:0]   BOARD_INIT  = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         manual,
    input  logic         step,
    output logic [2:0]   current_state,
    output logic         game_dificulty,
    output logic [323:0] full_board,
    output logic [161:0] colors,
    output logic [7:0]   position,
    output logic [1:0]   errors,
    output logic [3:0]   selected_number,
    output logic         victory_condition,
    output logic [6:0]   score,
    output logic [10:0]  time_in_seconds
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_PLAY = 3'b010,
        S_DONE = 3'b011
    } state_t;

    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam int unsigned ERR_MOD = (ERR_EVERY == 0) ? 1 : ERR_EVERY;

    // Both vectors are MSB-first by cell, so bit group i from the LSB is cell 80-i in each.
    function automatic logic [161:0] colors_from_board(input logic [323:0] b);
        logic [161:0] c;
        c = '0;
        for (int i = 0; i < 81; i++)
            c[2*i +: 2] = (b[4*i +: 4] != 4'd0) ? 2'b01 : 2'b00;
        return c;
    endfunction

    localparam logic [161:0] COLORS_INIT = colors_from_board(BOARD_INIT);

    state_t         state_q, state_d;
    logic [323:0]   board_q, board_d;
    logic [161:0]   colors_q, colors_d;
    logic [3:0]     row_q, row_d;
    logic [3:0]     col_q, col_d;
    logic [1:0]     errors_q, errors_d;
    logic [3:0]     sel_q, sel_d;
    logic           victory_q, victory_d;
    logic [6:0]     score_q, score_d;
    logic [6:0]     k_q, k_d;
    logic [SW-1:0]  step_q, step_d;

    logic [6:0] cell_idx;
    logic [6:0] rev_idx;
    logic [6:0] k_next;
    logic       is_err;
    logic       adv;

    assign cell_idx = 7'(row_q) * 7'd9 + 7'(col_q);
    assign rev_idx  = 7'd80 - cell_idx;
    assign k_next   = k_q + 7'd1;
    assign is_err   = (ERR_EVERY != 0) && ((32'(k_next) % ERR_MOD) == 0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            board_q   <= BOARD_INIT;
            colors_q  <= COLORS_INIT;
            row_q     <= '0;
            col_q     <= '0;
            errors_q  <= '0;
            sel_q     <= 4'd1;
            victory_q <= 1'b0;
            score_q   <= '0;
            k_q       <= '0;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            colors_q  <= colors_d;
            row_q     <= row_d;
            col_q     <= col_d;
            errors_q  <= errors_d;
            sel_q     <= sel_d;
            victory_q <= victory_d;
            score_q   <= score_d;
            k_q       <= k_d;
            step_q    <= step_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        colors_d  = colors_q;
        row_d     = row_q;
        col_d     = col_q;
        errors_d  = errors_q;
        sel_d     = sel_q;
        victory_d = victory_q;
        score_d   = score_q;
        k_d       = k_q;
        step_d    = step_q;
        adv       = 1'b0;

        if (state_q == S_PLAY) begin
            if (manual) begin
                step_d = '0;
                adv    = step;
            end else if (step_q == STEP_LAST) begin
                step_d = '0;
                adv    = 1'b1;
            end else begin
                step_d = step_q + SW'(1);
            end
        end

        // start outranks any advance sampled in the same cycle
        if (start) begin
            state_d   = S_PLAY;
            board_d   = BOARD_INIT;
            colors_d  = COLORS_INIT;
            row_d     = '0;
            col_d     = '0;
            errors_d  = '0;
            sel_d     = 4'd1;
            victory_d = 1'b0;
            score_d   = '0;
            k_d       = '0;
            step_d    = '0;
        end else if (adv) begin
            if (colors_q[{rev_idx, 1'b0} +: 2] == 2'b00) begin
                k_d = k_next;
                board_d[{rev_idx, 2'b00} +: 4] = sel_q;
                if (is_err) begin
                    colors_d[{rev_idx, 1'b0} +: 2] = 2'b11;
                    if (errors_q != 2'd3) errors_d = errors_q + 2'd1;
                end else begin
                    colors_d[{rev_idx, 1'b0} +: 2] = 2'b10;
                    if (score_q != 7'd99) score_d = score_q + 7'd1;
                end
                sel_d = (sel_q == 4'd9) ? 4'd1 : sel_q + 4'd1;
            end

            if (col_q == 4'd8) begin
                col_d = '0;
                row_d = (row_q == 4'd8) ? 4'd0 : row_q + 4'd1;
            end else begin
                col_d = col_q + 4'd1;
            end

            if (errors_d == 2'd3) begin
                state_d   = S_DONE;
                victory_d = 1'b0;
            end else if (k_d == 7'(MAX_ENTRIES)) begin
                state_d   = S_DONE;
                victory_d = 1'b1;
            end
        end
    end

`ifdef TEST_SEQ_TIMER_EN
    localparam int DW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_HZ - 1);

    logic [DW-1:0] div_q;
    logic [10:0]   time_q;

    always_ff @(posedge clk) begin
        if (reset || start) begin
            div_q  <= '0;
            time_q <= '0;
        end else if (state_q == S_PLAY) begin
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                if (time_q != 11'h7FF) time_q <= time_q + 11'd1;
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

    assign time_in_seconds = time_q;
`else
    assign time_in_seconds = '0;
`endif

    assign current_state     = state_q;
    assign game_dificulty    = DIFFICULTY;
    assign full_board        = board_q;
    assign colors            = colors_q;
    assign position          = {row_q, col_q};
    assign errors            = errors_q;
    assign selected_number   = sel_q;
    assign victory_condition = victory_q;
    assign score             = score_q;

endmodule

// File: tb/tb_test_game_sequencer.sv
// Scoreboard bench for test_game_sequencer: three instances (win/auto, loss, long-run saturation).
// Expectations are time-stamped by cycle and checked by an independent negedge monitor.
`timescale 1ns/1ps
module tb_test_game_sequencer;

    localparam int NI = 3;

`ifdef TEST_SEQ_TIMER_EN
    localparam int TEN = 1;
`else
    localparam int TEN = 0;
`endif

    localparam int F_STATE = 0, F_POS = 1, F_SEL = 2, F_ERR = 3, F_SCORE = 4, F_VIC = 5,
                   F_TIME = 6, F_NIB = 7, F_COL = 8, F_BINIT = 9, F_CINIT = 10, F_DIFF = 11;

    function automatic int init_nib(int i);
        if (i == 0 || (i >= 2 && i <= 6)) return 0;
        return (i % 9) + 1;
    endfunction

    function automatic logic [323:0] mk_board();
        logic [323:0] b;
        b = '0;
        for (int i = 0; i < 81; i++) b[323-4*i -: 4] = 4'(init_nib(i));
        return b;
    endfunction

    function automatic logic [161:0] mk_colors();
        logic [161:0] c;
        c = '0;
        for (int i = 0; i < 81; i++) c[161-2*i -: 2] = (init_nib(i) != 0) ? 2'b01 : 2'b00;
        return c;
    endfunction

    localparam logic [323:0] B_INIT = mk_board();
    localparam logic [161:0] C_INIT = mk_colors();

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         start  [NI];
    logic         manual [NI];
    logic         step   [NI];
    logic [2:0]   st     [NI];
    logic         diff   [NI];
    logic [323:0] brd    [NI];
    logic [161:0] col    [NI];
    logic [7:0]   pos    [NI];
    logic [1:0]   err    [NI];
    logic [3:0]   sel    [NI];
    logic         vic    [NI];
    logic [6:0]   scr    [NI];
    logic [10:0]  tim    [NI];

    test_game_sequencer #(.CLK_HZ(10), .STEP_CYCLES(4), .ERR_EVERY(3), .MAX_ENTRIES(5),
                          .DIFFICULTY(1'b1), .BOARD_INIT(B_INIT)) u_main (
        .clk(clk), .reset(reset), .start(start[0]), .manual(manual[0]), .step(step[0]),
        .current_state(st[0]), .game_dificulty(diff[0]), .full_board(brd[0]), .colors(col[0]),
        .position(pos[0]), .errors(err[0]), .selected_number(sel[0]),
        .victory_condition(vic[0]), .score(scr[0]), .time_in_seconds(tim[0]));

    test_game_sequencer #(.CLK_HZ(10), .STEP_CYCLES(4), .ERR_EVERY(1), .MAX_ENTRIES(5),
                          .DIFFICULTY(1'b1), .BOARD_INIT(B_INIT)) u_loss (
        .clk(clk), .reset(reset), .start(start[1]), .manual(manual[1]), .step(step[1]),
        .current_state(st[1]), .game_dificulty(diff[1]), .full_board(brd[1]), .colors(col[1]),
        .position(pos[1]), .errors(err[1]), .selected_number(sel[1]),
        .victory_condition(vic[1]), .score(scr[1]), .time_in_seconds(tim[1]));

    test_game_sequencer #(.CLK_HZ(10), .STEP_CYCLES(4), .ERR_EVERY(0), .MAX_ENTRIES(127),
                          .DIFFICULTY(1'b1), .BOARD_INIT(B_INIT)) u_long (
        .clk(clk), .reset(reset), .start(start[2]), .manual(manual[2]), .step(step[2]),
        .current_state(st[2]), .game_dificulty(diff[2]), .full_board(brd[2]), .colors(col[2]),
        .position(pos[2]), .errors(err[2]), .selected_number(sel[2]),
        .victory_condition(vic[2]), .score(scr[2]), .time_in_seconds(tim[2]));

    typedef struct {
        string       name;
        int          inst;
        int          fld;
        int          arg;
        int          due;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_err   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int inst, int fld, int arg);
        case (fld)
            F_STATE: return 32'(st[inst]);
            F_POS:   return 32'(pos[inst]);
            F_SEL:   return 32'(sel[inst]);
            F_ERR:   return 32'(err[inst]);
            F_SCORE: return 32'(scr[inst]);
            F_VIC:   return 32'(vic[inst]);
            F_TIME:  return 32'(tim[inst]);
            F_NIB:   return 32'(brd[inst][323-4*arg -: 4]);
            F_COL:   return 32'(col[inst][161-2*arg -: 2]);
            F_BINIT: return 32'(brd[inst] == B_INIT);
            F_CINIT: return 32'(col[inst] == C_INIT);
            F_DIFF:  return 32'(diff[inst]);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_at(string nm, int inst, int fld, int arg, int due, logic [31:0] ex);
        exp_t e;
        e.name = nm; e.inst = inst; e.fld = fld; e.arg = arg; e.due = due; e.exp = ex;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        int i;
        logic [31:0] a;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due <= cyc) begin
                a = actual(sb[i].inst, sb[i].fld, sb[i].arg);
                n_check++;
                if (a !== sb[i].exp) begin
                    n_err++;
                    $display("FAIL %s (inst %0d, cycle %0d): got %0h expected %0h",
                             sb[i].name, sb[i].inst, cyc, a, sb[i].exp);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_step(int k);
        step[k] = 1'b1;
        tick();
        step[k] = 1'b0;
    endtask

    task automatic pulse_start(int k);
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
    endtask

    initial begin
        int c0;
        int cl;
        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            start[k] = 1'b0; manual[k] = 1'b1; step[k] = 1'b0;
        end
        manual[2] = 1'b0;
        tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        expect_at("rst_state",  0, F_STATE, 0, cyc, 0);
        expect_at("rst_pos",    0, F_POS,   0, cyc, 0);
        expect_at("rst_sel",    0, F_SEL,   0, cyc, 1);
        expect_at("rst_col0",   0, F_COL,   0, cyc, 0);
        expect_at("rst_col1",   0, F_COL,   1, cyc, 1);
        expect_at("rst_score",  0, F_SCORE, 0, cyc, 0);
        expect_at("rst_time",   0, F_TIME,  0, cyc, 0);
        expect_at("rst_board",  0, F_BINIT, 0, cyc, 1);
        expect_at("rst_diff",   0, F_DIFF,  0, cyc, 1);
        reset = 1'b0;

        pulse_start(2);
        cl = cyc;
        expect_at("long_pos1",   2, F_POS,   0, cl + 4,     8'h01);
        expect_at("long_nib0",   2, F_NIB,   0, cl + 4,     1);
        expect_at("long_t2046",  2, F_TIME,  0, cl + 20469, TEN ? 2046 : 0);
        expect_at("long_t2047",  2, F_TIME,  0, cl + 20470, TEN ? 2047 : 0);
        expect_at("long_tsat",   2, F_TIME,  0, cl + 20500, TEN ? 2047 : 0);
        expect_at("long_score",  2, F_SCORE, 0, cl + 20500, 6);
        expect_at("long_errors", 2, F_ERR,   0, cl + 20500, 0);
        expect_at("long_state",  2, F_STATE, 0, cl + 20500, 3'b010);

        pulse_step(0);
        expect_at("idle_step_pos", 0, F_POS, 0, cyc, 0);
        expect_at("idle_state",    0, F_STATE, 0, cyc, 0);

        // win path
        pulse_start(0);
        expect_at("win_start_state", 0, F_STATE, 0, cyc, 3'b010);
        for (int s = 1; s <= 8; s++) begin
            pulse_step(0);
            if (s == 5) begin
                expect_at("win5_pos",   0, F_POS,   0, cyc, 8'h05);
                expect_at("win5_score", 0, F_SCORE, 0, cyc, 3);
                expect_at("win5_state", 0, F_STATE, 0, cyc, 3'b010);
                expect_at("win5_err",   0, F_ERR,   0, cyc, 1);
            end
            if (s == 6) begin
                expect_at("win6_state", 0, F_STATE, 0, cyc, 3'b011);
                expect_at("win6_vic",   0, F_VIC,   0, cyc, 1);
                expect_at("win6_pos",   0, F_POS,   0, cyc, 8'h06);
            end
        end
        expect_at("win_nib0",  0, F_NIB,   0, cyc, 1);
        expect_at("win_nib2",  0, F_NIB,   2, cyc, 2);
        expect_at("win_nib3",  0, F_NIB,   3, cyc, 3);
        expect_at("win_nib6",  0, F_NIB,   6, cyc, 0);
        expect_at("win_col0",  0, F_COL,   0, cyc, 2'b10);
        expect_at("win_col1",  0, F_COL,   1, cyc, 2'b01);
        expect_at("win_col3",  0, F_COL,   3, cyc, 2'b11);
        expect_at("win_state", 0, F_STATE, 0, cyc, 3'b011);
        expect_at("win_vic",   0, F_VIC,   0, cyc, 1);
        expect_at("win_err",   0, F_ERR,   0, cyc, 1);
        expect_at("win_score", 0, F_SCORE, 0, cyc, 4);
        expect_at("win_sel",   0, F_SEL,   0, cyc, 6);
        expect_at("win_pos",   0, F_POS,   0, cyc, 8'h06);

        // start and step together: start wins
        pulse_start(0);
        for (int s = 0; s < 3; s++) pulse_step(0);
        expect_at("pre_restart_score", 0, F_SCORE, 0, cyc, 2);
        expect_at("pre_restart_pos",   0, F_POS,   0, cyc, 8'h03);
        start[0] = 1'b1;
        step[0]  = 1'b1;
        tick();
        start[0] = 1'b0;
        step[0]  = 1'b0;
        expect_at("restart_score", 0, F_SCORE, 0, cyc, 0);
        expect_at("restart_pos",   0, F_POS,   0, cyc, 8'h00);
        expect_at("restart_board", 0, F_BINIT, 0, cyc, 1);
        expect_at("restart_cols",  0, F_CINIT, 0, cyc, 1);
        expect_at("restart_sel",   0, F_SEL,   0, cyc, 1);
        expect_at("restart_state", 0, F_STATE, 0, cyc, 3'b010);

        // auto mode
        manual[0] = 1'b0;
        pulse_start(0);
        c0 = cyc;
        expect_at("auto_pos_c3",   0, F_POS,   0, c0 + 3,  8'h00);
        expect_at("auto_pos_c4",   0, F_POS,   0, c0 + 4,  8'h01);
        expect_at("auto_nib0_c4",  0, F_NIB,   0, c0 + 4,  1);
        expect_at("auto_pos_c7",   0, F_POS,   0, c0 + 7,  8'h01);
        expect_at("auto_pos_c8",   0, F_POS,   0, c0 + 8,  8'h02);
        expect_at("auto_time_c9",  0, F_TIME,  0, c0 + 9,  0);
        expect_at("auto_time_c10", 0, F_TIME,  0, c0 + 10, TEN ? 1 : 0);
        expect_at("auto_pos_c12",  0, F_POS,   0, c0 + 12, 8'h03);
        expect_at("auto_nib2_c12", 0, F_NIB,   2, c0 + 12, 2);
        expect_at("auto_sel_c12",  0, F_SEL,   0, c0 + 12, 3);
        expect_at("auto_state_c60", 0, F_STATE, 0, c0 + 60, 3'b011);
        expect_at("auto_vic_c60",   0, F_VIC,   0, c0 + 60, 1);
        expect_at("auto_time_c60",  0, F_TIME,  0, c0 + 60, TEN ? 2 : 0);
        pulse_step(0);
        repeat (62) tick();

        // loss path
        pulse_start(1);
        for (int s = 1; s <= 4; s++) begin
            pulse_step(1);
            if (s == 3) begin
                expect_at("loss3_err",   1, F_ERR,   0, cyc, 2);
                expect_at("loss3_state", 1, F_STATE, 0, cyc, 3'b010);
                expect_at("loss3_col2",  1, F_COL,   2, cyc, 2'b11);
            end
        end
        expect_at("loss_err",   1, F_ERR,   0, cyc, 3);
        expect_at("loss_state", 1, F_STATE, 0, cyc, 3'b011);
        expect_at("loss_vic",   1, F_VIC,   0, cyc, 0);
        expect_at("loss_score", 1, F_SCORE, 0, cyc, 0);

        for (int n = 0; n < 25000 && sb.size() != 0; n++) tick();
        tick();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_check);
        $finish;
    end

endmodule
